// File: rtl/dot_sched.sv
// Round-robin scheduler sharing one matrix_dot engine among NREQ requesters.
// Optional WAIT timeout abort is enabled by defining DOT_SCHED_TIMEOUT_EN.
module dot_sched #(
    parameter int NREQ      = 4,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*128-1:0]   req_a,
    input  logic [NREQ*128-1:0]   req_b,
    output logic [NREQ-1:0]       req_ack,
    output logic                  rsp_valid,
    output logic [2:0]            rsp_id,
    output logic [15:0]           rsp_c,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  eng_start,
    output logic [127:0]          eng_a,
    output logic [127:0]          eng_b,
    input  logic [15:0]           eng_c,
    input  logic                  eng_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  owner;
    logic [SW-1:0]  issue_cnt;
    logic [127:0]   a_q;
    logic [127:0]   b_q;
    logic           any_req;
    logic [IW-1:0]  pick;
    int             idx;

    // Search ptr+NREQ down to ptr+1 so the candidate nearest ptr+1 is written last and wins.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        any_req = 1'b0;
        pick    = ptr;
        idx     = 0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req_valid[idx]) begin
                any_req = 1'b1;
                pick    = IW'(idx);
            end
        end
    end

    // The engine only ever sees the latched operands, so they stay stable through RESP.
    assign eng_a = a_q;
    assign eng_b = b_q;

`ifdef DOT_SCHED_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            owner     <= '0;
            issue_cnt <= '0;
            // NOTE: operand latches are plain registers and are reset so eng_a/eng_b read 0 after reset.
            a_q       <= '0;
            b_q       <= '0;
            req_ack   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
`ifdef DOT_SCHED_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            req_ack   <= '0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_q          <= req_a[int'(pick)*128 +: 128];
                        b_q          <= req_b[int'(pick)*128 +: 128];
                        ptr          <= pick;
                        owner        <= pick;
                        req_ack[pick] <= 1'b1;
                        eng_start    <= 1'b1;
                        busy         <= 1'b1;
                        issue_cnt    <= '0;
                        state        <= ISSUE;
                    end
                end
                // eng_done is ignored here: the engine may still hold done from the previous op.
                ISSUE: begin
                    if (issue_cnt == SW'(START_CYC - 1)) begin
                        eng_start <= 1'b0;
                        state     <= WAIT;
`ifdef DOT_SCHED_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (eng_done) begin
                        rsp_c     <= eng_c;
                        rsp_id    <= 3'(owner);
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef DOT_SCHED_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        rsp_c     <= '0;
                        rsp_id    <= 3'(owner);
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_sched.sv
// Scoreboard bench for dot_sched: requester agents, a behavioural engine and a
// high-level round-robin/dot-product model feeding an expected-response queue.
module tb_dot_sched;

    localparam int NREQ      = 4;
    localparam int START_CYC = 2;
    localparam int TIMEOUT   = 255;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*128-1:0] req_a;
    logic [NREQ*128-1:0] req_b;
    logic [NREQ-1:0]     req_ack;
    logic                rsp_valid;
    logic [2:0]          rsp_id;
    logic [15:0]         rsp_c;
    logic                rsp_err;
    logic                busy;
    logic                eng_start;
    logic [127:0]        eng_a;
    logic [127:0]        eng_b;
    logic [15:0]         eng_c;
    logic                eng_done;

    dot_sched #(.NREQ(NREQ), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_err(rsp_err),
        .busy(busy), .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_c(eng_c), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] c;
        logic        err;
        int          gnt_n;
    } exp_t;

    typedef struct {
        int           id;
        logic [127:0] a;
        logic [127:0] b;
    } job_t;

    exp_t         sbq[$];
    job_t         jobq[$];
    int           gnt_log[$];
    int           errors = 0;
    int           checks = 0;
    int           ncnt = 0;
    int           idle_at = 0;
    bit           mbusy = 1'b0;
    int           mptr = NREQ - 1;
    logic [NREQ-1:0] pend_prev = '0;
    int           rsp_cnt[NREQ] = '{default: 0};
    int           seen[NREQ] = '{default: 0};
    int           ag_state[NREQ] = '{default: 0};
    logic [127:0] cur_a[NREQ];
    logic [127:0] cur_b[NREQ];
    bit           gate_all = 1'b1;
    bit           eng_hang = 1'b0;
    int           run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference dot product: plain sum of 16 byte products, truncated to 16 bits.
    function automatic logic [15:0] dot(input logic [127:0] a, input logic [127:0] b);
        int s = 0;
        for (int k = 0; k < 16; k++) s += int'(a[k*8 +: 8]) * int'(b[k*8 +: 8]);
        return s[15:0];
    endfunction

    // Fair round robin: first pending id after the last winner, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
        for (int s = 1; s <= NREQ; s++)
            if (p[(last + s) % NREQ]) return (last + s) % NREQ;
        return -1;
    endfunction

    // Requester agents: raise valid with a job's operands, drop on ack, wait for own response.
    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                req_valid = '0;
                for (int i = 0; i < NREQ; i++) begin
                    ag_state[i] = 0;
                    seen[i]     = rsp_cnt[i];
                end
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    case (ag_state[i])
                        0: if (gate_all || $urandom_range(0, 2) == 0) begin
                            for (int k = 0; k < jobq.size(); k++) begin
                                if (jobq[k].id == i) begin
                                    cur_a[i] = jobq[k].a;
                                    cur_b[i] = jobq[k].b;
                                    req_a[i*128 +: 128] = jobq[k].a;
                                    req_b[i*128 +: 128] = jobq[k].b;
                                    req_valid[i] = 1'b1;
                                    ag_state[i]  = 1;
                                    jobq.delete(k);
                                    break;
                                end
                            end
                        end
                        1: if (req_ack[i]) begin
                            req_valid[i] = 1'b0;
                            ag_state[i]  = 2;
                        end
                        default: if (rsp_cnt[i] != seen[i]) begin
                            seen[i]     = rsp_cnt[i];
                            ag_state[i] = 0;
                        end
                    endcase
                end
            end
        end
    end

    // Engine: restarts on a rising start, drops done, returns the result after a random latency
    // and then holds done (level) or pulses it once.
    initial begin
        logic [15:0] res;
        int          cnt;
        bit          pulse;
        logic        start_d;
        eng_c = '0; eng_done = 1'b0; cnt = 0; pulse = 1'b0; start_d = 1'b0; res = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                eng_done = 1'b0;
                cnt      = 0;
                start_d  = 1'b0;
            end else begin
                if (pulse && eng_done) eng_done = 1'b0;
                if (eng_start && !start_d) begin
                    eng_done = 1'b0;
                    res      = dot(eng_a, eng_b);
                    pulse    = ($urandom_range(0, 1) == 1);
                    cnt      = eng_hang ? 0 : (pulse ? $urandom_range(2, 6) : $urandom_range(1, 6));
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        eng_c    = res;
                        eng_done = 1'b1;
                    end
                end
                start_d = eng_start;
            end
        end
    end

    // Monitor: predicts grants, pushes expected responses, pops and compares on rsp_valid.
    initial begin
        forever begin
            @(negedge clk);
            ncnt++;
            if (rst) begin
                sbq.delete();
                mptr    = NREQ - 1;
                mbusy   = 1'b0;
                idle_at = ncnt + 2;
                run     = 0;
            end else begin
                if (!mbusy && ncnt >= idle_at && pend_prev != '0) begin
                    int w;
                    logic [NREQ-1:0] oh;
                    exp_t e;
                    w  = rr_pick(pend_prev, mptr);
                    oh = '0;
                    oh[w] = 1'b1;
                    check("grant_ack", 32'(req_ack), 32'(oh));
                    mptr     = w;
                    mbusy    = 1'b1;
                    e.id     = w;
                    e.err    = eng_hang;
                    e.c      = eng_hang ? 16'h0 : dot(cur_a[w], cur_b[w]);
                    e.gnt_n  = ncnt;
                    sbq.push_back(e);
                    gnt_log.push_back(w);
                end else if (req_ack != '0) begin
                    check("spurious_ack", 32'(req_ack), 32'h0);
                end
                check("busy", 32'(busy), 32'(mbusy));
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        check("rsp_unexpected_id", 32'(rsp_id), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("rsp_id", 32'(rsp_id), 32'(e.id));
                        check("rsp_c", 32'(rsp_c), 32'(e.c));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (e.err)
                            check("timeout_latency", 32'(ncnt - e.gnt_n), 32'(START_CYC + TIMEOUT));
                        else
                            check("min_latency", 32'(ncnt - e.gnt_n >= START_CYC + 1), 32'h1);
                        rsp_cnt[e.id]++;
                    end
                    mbusy   = 1'b0;
                    idle_at = ncnt + 2;
                end
                if (eng_start) begin
                    run++;
                end else if (run > 0) begin
                    check("start_len", 32'(run), 32'(START_CYC));
                    run = 0;
                end
            end
            pend_prev = req_valid;
        end
    end

    task automatic drain(input int budget);
        bit idle;
        int k;
        idle = 1'b0;
        k = 0;
        while (!idle && k < budget) begin
            @(posedge clk); #2;
            k++;
            idle = (jobq.size() == 0) && (sbq.size() == 0) && !mbusy;
            for (int i = 0; i < NREQ; i++) if (ag_state[i] != 0) idle = 1'b0;
        end
        if (!idle) check("drain_timeout", 32'(k), 32'(budget + 1));
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_ack"}, 32'(req_ack), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
        check({tag, "_rsp_c"}, 32'(rsp_c), 32'h0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_eng_start"}, 32'(eng_start), 32'h0);
        check({tag, "_eng_a_nz"}, 32'(|eng_a), 32'h0);
        check({tag, "_eng_b_nz"}, 32'(|eng_b), 32'h0);
    endtask

    task automatic push_job(input int id, input logic [127:0] a, input logic [127:0] b);
        job_t j;
        j.id = id;
        j.a  = a;
        j.b  = b;
        jobq.push_back(j);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] a, b;
        bit           hit;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        outputs_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // Single request from id 2: a[k]=k+1, b[k]=2 -> 272.
        for (int k = 0; k < 16; k++) begin
            a[k*8 +: 8] = 8'(k + 1);
            b[k*8 +: 8] = 8'd2;
        end
        push_job(2, a, b);
        drain(200);
        check("single_c", 32'(rsp_c), 32'd272);
        check("single_id", 32'(rsp_id), 32'd2);

        // Overflow: every byte 255 -> 1040400 mod 65536.
        push_job(1, {128{1'b1}}, {128{1'b1}});
        drain(200);
        check("overflow_c", 32'(rsp_c), 32'hE010);
        check("overflow_err", 32'(rsp_err), 32'h0);

        // Asynchronous reset in the middle of ISSUE.
        push_job(3, rnd128(), rnd128());
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            hit = eng_start;
        end
        check("issue_reached", 32'(hit), 32'h1);
        #2 rst = 1'b1;
        #1 outputs_zero("midop_reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // All four together after reset, each twice: order starts 0,1,2,3,0.
        gnt_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push_job(i, rnd128(), rnd128());
        drain(500);
        check("order_count", 32'(gnt_log.size()), 32'd8);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++)
            check("fair_order", 32'(gnt_log[k]), 32'(k % NREQ));

        // Randomised traffic with random arrival and engine latency/done style.
        gate_all = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) push_job($urandom_range(0, NREQ - 1), {128{1'b1}}, rnd128());
            else push_job($urandom_range(0, NREQ - 1), rnd128(), rnd128());
        end
        drain(4000);
        gate_all = 1'b1;

`ifdef DOT_SCHED_TIMEOUT_EN
        // Engine never completes: abort after TIMEOUT WAIT cycles, then normal service.
        eng_hang = 1'b1;
        push_job(0, rnd128(), rnd128());
        drain(600);
        eng_hang = 1'b0;
        check("timeout_err_held", 32'(rsp_err), 32'h1);
        push_job(2, rnd128(), rnd128());
        drain(200);
        check("after_timeout_err", 32'(rsp_err), 32'h0);
`endif

        check("sb_empty", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

endmodule
